ttl_piso_frame_tx: RTL and testbench

Parameterized parallel-in, serial-out frame transmitter for the TTL-style chip library. It captures a WIDTH-bit word on a load request and shifts it out LSB-first on a single line: start bit, data, optional parity, then stop bit. Each bit is held for DIVIDER clocks. It is the transmitting end of the library's serial link, driving the line that the serial-in/parallel-out receiver chips sample.

---
 rtl/ttl_piso_frame_tx.sv | 107 ++++++++++
 tb/tb_ttl_piso_frame_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ttl_piso_frame_tx.sv
// ttl_piso_frame_tx: parallel-in serial-out frame transmitter (start, LSB-first data, optional parity, stop)
// Ports: Clk clock; Clear sync active-high reset; Load load request; D parallel word;
//        Q serial line (idle high); Busy frame in progress; Done one-clock completion pulse.
// Macro TTL_PISO_FRAME_TX_PARITY_EN inserts an even-parity bit between data and stop.
module ttl_piso_frame_tx #(
    parameter int WIDTH      = 8,
    parameter int DIVIDER    = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic             Q,
    output logic             Busy,
    output logic             Done
);
    localparam int DW = $clog2(DIVIDER) + 1;
    localparam int BW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] sh_next;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             last;
    logic             unused_delay;
`ifdef TTL_PISO_FRAME_TX_PARITY_EN
    logic             par;
`endif

    // Line delays only matter to timing simulation models; the RTL has none.
    assign unused_delay = (DELAY_RISE + DELAY_FALL) != 0;
    assign sh_next      = shreg >> 1;
    assign last         = div_cnt == DW'(DIVIDER - 1);

    always_ff @(posedge Clk) begin
        if (Clear) begin
            state   <= IDLE;
            Q       <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
`ifdef TTL_PISO_FRAME_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            Done    <= 1'b0;
            div_cnt <= last ? '0 : div_cnt + DW'(1);
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (Load) begin
                        state   <= START;
                        shreg   <= D;
                        bit_cnt <= '0;
                        Q       <= 1'b0;
                        Busy    <= 1'b1;
`ifdef TTL_PISO_FRAME_TX_PARITY_EN
                        par     <= ^D;
`endif
                    end
                end
                START: if (last) begin
                    state <= DATA;
                    Q     <= shreg[0];
                end
                DATA: if (last) begin
                    shreg   <= sh_next;
                    bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt == BW'(WIDTH - 1)) begin
`ifdef TTL_PISO_FRAME_TX_PARITY_EN
                        state <= PARITY;
                        Q     <= par;
`else
                        state <= STOP;
                        Q     <= 1'b1;
`endif
                    end else begin
                        Q <= sh_next[0];
                    end
                end
`ifdef TTL_PISO_FRAME_TX_PARITY_EN
                PARITY: if (last) begin
                    state <= STOP;
                    Q     <= 1'b1;
                end
`endif
                STOP: if (last) begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    Q     <= 1'b1;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ttl_piso_frame_tx.sv
// tb_ttl_piso_frame_tx: directed bench for ttl_piso_frame_tx (WIDTH=8/DIVIDER=4 and WIDTH=4/DIVIDER=1)
module tb_ttl_piso_frame_tx;
`ifdef TTL_PISO_FRAME_TX_PARITY_EN
    localparam int          NB   = 11;
    localparam int          NB4  = 7;
    localparam logic [10:0] F_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] F_07 = 11'b1_1_00000111_0;
    localparam logic [10:0] F_3C = 11'b1_0_00111100_0;
    localparam logic [6:0]  F_9  = 7'b1_0_1001_0;
`else
    localparam int          NB   = 10;
    localparam int          NB4  = 6;
    localparam logic [10:0] F_A5 = 11'b0_1_10100101_0;
    localparam logic [10:0] F_07 = 11'b0_1_00000111_0;
    localparam logic [10:0] F_3C = 11'b0_1_00111100_0;
    localparam logic [6:0]  F_9  = 7'b0_1_1001_0;
`endif

    logic       clk = 1'b0;
    logic       clear, load8, load4;
    logic [7:0] d8;
    logic [3:0] d4;
    logic       q8, busy8, done8, q4, busy4, done4;
    int         vectors = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    ttl_piso_frame_tx #(.WIDTH(8), .DIVIDER(4)) u8 (
        .Clk(clk), .Clear(clear), .Load(load8), .D(d8), .Q(q8), .Busy(busy8), .Done(done8));
    ttl_piso_frame_tx #(.WIDTH(4), .DIVIDER(1)) u4 (
        .Clk(clk), .Clear(clear), .Load(load4), .D(d4), .Q(q4), .Busy(busy4), .Done(done4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Called one edge after Load was sampled; walks every clock of the frame and ends on the Done cycle.
    task automatic check_frame(input string tag, input logic [10:0] bits, input int glitch);
        for (int k = 0; k < NB * 4; k++) begin
            chk({tag, "_q"}, q8, bits[k / 4]);
            chk({tag, "_busy"}, busy8, 1'b1);
            chk({tag, "_done"}, done8, 1'b0);
            if (k == glitch) begin
                load8 = 1'b1;
                d8 = 8'hFF;
            end
            tick();
            if (k == glitch) load8 = 1'b0;
        end
        chk({tag, "_end_q"}, q8, 1'b1);
        chk({tag, "_end_busy"}, busy8, 1'b0);
        chk({tag, "_end_done"}, done8, 1'b1);
    endtask

    initial begin
        clear = 1'b1; load8 = 1'b0; load4 = 1'b0; d8 = '0; d4 = '0;
        tick();
        tick();
        chk("rst_q", q8, 1'b1);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        clear = 1'b0;
        tick();
        load8 = 1'b1; d8 = 8'hA5;
        tick();
        load8 = 1'b0; d8 = 8'h00;
        check_frame("a5", F_A5, -1);
        tick();
        chk("a5_done_once", done8, 1'b0);
        load8 = 1'b1; d8 = 8'h07;
        tick();
        load8 = 1'b0;
        check_frame("h07", F_07, -1);
        tick();
        load8 = 1'b1; d8 = 8'hA5;
        tick();
        load8 = 1'b0;
        check_frame("ign", F_A5, 11);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("ign_idle_busy", busy8, 1'b0);
            chk("ign_idle_done", done8, 1'b0);
        end
        load8 = 1'b1; d8 = 8'h3C;
        tick();
        check_frame("b2b1", F_3C, -1);
        tick();
        check_frame("b2b2", F_3C, -1);
        load8 = 1'b0;
        tick();
        chk("b2b_idle_busy", busy8, 1'b0);
        chk("b2b_idle_q", q8, 1'b1);
        load8 = 1'b1; d8 = 8'hA5;
        tick();
        load8 = 1'b0;
        repeat (14) tick();
        chk("clr_pre_busy", busy8, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_q", q8, 1'b1);
        chk("clr_busy", busy8, 1'b0);
        chk("clr_done", done8, 1'b0);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("clr_nodone", done8, 1'b0);
        end
        clear = 1'b1; load8 = 1'b1;
        tick();
        chk("clrld_busy", busy8, 1'b0);
        chk("clrld_q", q8, 1'b1);
        clear = 1'b0; load8 = 1'b0;
        tick();
        chk("clrld_busy2", busy8, 1'b0);
        load4 = 1'b1; d4 = 4'b1001;
        tick();
        load4 = 1'b0; d4 = 4'b0000;
        for (int k = 0; k < NB4; k++) begin
            chk("d1_q", q4, F_9[k]);
            chk("d1_busy", busy4, 1'b1);
            chk("d1_done", done4, 1'b0);
            tick();
        end
        chk("d1_end_q", q4, 1'b1);
        chk("d1_end_busy", busy4, 1'b0);
        chk("d1_end_done", done4, 1'b1);
        tick();
        chk("d1_done_once", done4, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
